// File: rtl/adc_snapshot_buffer.sv
// Triggered dual-channel ADC snapshot buffer: circular capture with run-time pre-trigger depth, frozen readout.
// Optional build macro ADC_SNAP_DECIM_EN adds the decim port and keeps only every (decim+1)-th sample.
module adc_snapshot_buffer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_ch0,
    input  logic [DATA_W-1:0]     s_ch1,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic                  trig_falling,
    input  logic [ADDR_W-1:0]     pretrig_len,
    input  logic [ADDR_W:0]       post_len,
    input  logic [ADDR_W-1:0]     rd_addr,
`ifdef ADC_SNAP_DECIM_EN
    input  logic [7:0]            decim,
`endif
    output logic [2*DATA_W-1:0]   rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_W:0]       capture_len
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [2*DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_wp;
    logic [ADDR_W-1:0]     r_trig_addr;
    logic [ADDR_W-1:0]     r_pre;
    logic [ADDR_W:0]       r_post;
    logic [ADDR_W:0]       r_cnt;
    logic [ADDR_W:0]       r_capture_len;
    logic signed [DATA_W-1:0] r_prev;
    logic                  r_triggered;
    logic                  r_force_pend;
    logic                  r_busy;
    logic                  r_done;
    logic [2*DATA_W-1:0]   r_rd_data;

    logic                  w_accept;
    logic                  w_arm_ok;
    logic                  w_wr_en;
    logic                  w_fire;
    logic                  w_cross;
    logic [ADDR_W:0]       w_post_req;
    logic [ADDR_W:0]       w_post_max;
    logic [ADDR_W:0]       w_post_clamp;
    logic [ADDR_W:0]       w_cnt_inc;
    logic [ADDR_W-1:0]     w_raddr;

    assign w_arm_ok = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef ADC_SNAP_DECIM_EN
    logic [7:0] r_decim;
    logic [7:0] r_dcnt;

    assign w_accept = s_valid && (r_dcnt == 8'd0);

    // Decimation phase counter; restarts at arm so the first sample after arm is kept
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_decim <= 8'd0;
            r_dcnt  <= 8'd0;
        end else if (w_arm_ok) begin
            r_decim <= decim;
            r_dcnt  <= 8'd0;
        end else if (s_valid) begin
            r_dcnt  <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
        end
    end
`else
    assign w_accept = s_valid;
`endif

    // Pretrig cannot exceed DEPTH-1 by width; post is limited to the remaining space
    assign w_post_req   = (post_len == '0) ? ONE_L : post_len;
    assign w_post_max   = DEPTH_L - {1'b0, pretrig_len};
    assign w_post_clamp = (w_post_req > w_post_max) ? w_post_max : w_post_req;
    assign w_cnt_inc    = r_cnt + ONE_L;

    assign w_cross = trig_falling ?
        ((r_prev >= $signed(trig_level)) && ($signed(s_ch0) <  $signed(trig_level))) :
        ((r_prev <  $signed(trig_level)) && ($signed(s_ch0) >= $signed(trig_level)));

    assign w_raddr = (r_trig_addr - r_pre) + rd_addr;

    // Next-state, write enable and trigger decision
    always_comb begin
        w_state_nx = r_state;
        w_wr_en    = 1'b0;
        w_fire     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    w_state_nx = (pretrig_len == '0) ? S_WAIT : S_PRE;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_PRE: begin
                if (w_accept) begin
                    w_wr_en    = 1'b1;
                    w_state_nx = (w_cnt_inc == {1'b0, r_pre}) ? S_WAIT : S_PRE;
                end else begin
                    w_state_nx = S_PRE;
                end
            end
            S_WAIT: begin
                if (w_accept && (w_cross || force_trig || r_force_pend)) begin
                    w_wr_en    = 1'b1;
                    w_fire     = 1'b1;
                    w_state_nx = (r_post == ONE_L) ? S_DONE : S_POST;
                end else begin
                    w_wr_en    = w_accept;
                    w_state_nx = S_WAIT;
                end
            end
            S_POST: begin
                if (w_accept) begin
                    w_wr_en    = 1'b1;
                    w_state_nx = (w_cnt_inc == r_post) ? S_DONE : S_POST;
                end else begin
                    w_state_nx = S_POST;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        if (abort) begin
            w_state_nx = S_IDLE;
            w_wr_en    = 1'b0;
            w_fire     = 1'b0;
        end else begin
            w_wr_en    = w_wr_en;
        end
    end

    // State register, capture bookkeeping and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wp          <= '0;
            r_trig_addr   <= '0;
            r_pre         <= '0;
            r_post        <= '0;
            r_cnt         <= '0;
            r_capture_len <= '0;
            r_prev        <= '0;
            r_triggered   <= 1'b0;
            r_force_pend  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx == S_PRE) || (w_state_nx == S_WAIT) || (w_state_nx == S_POST);
            r_done  <= (w_state_nx == S_DONE);
            if (w_accept) begin
                r_prev <= s_ch0;
            end
            if (w_wr_en) begin
                r_wp <= r_wp + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (w_arm_ok) begin
                r_pre         <= pretrig_len;
                r_post        <= w_post_clamp;
                r_capture_len <= {1'b0, pretrig_len} + w_post_clamp;
                r_cnt         <= '0;
                r_triggered   <= 1'b0;
                r_force_pend  <= 1'b0;
            end else if (abort) begin
                r_triggered   <= 1'b0;
                r_force_pend  <= 1'b0;
            end else if (w_fire) begin
                r_triggered   <= 1'b1;
                r_trig_addr   <= r_wp;
                r_cnt         <= ONE_L;
                r_force_pend  <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_cnt <= w_cnt_inc;
                end
                // A force without an accepted sample waits for the next one
                if ((r_state == S_WAIT) && force_trig) begin
                    r_force_pend <= 1'b1;
                end
            end
        end
    end

    // Sample RAM write port
    always_ff @(posedge sys_clk) begin
        if (w_wr_en) begin
            r_mem[r_wp] <= {s_ch1, s_ch0};
        end
    end

    // Registered readout relative to the oldest kept sample
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_raddr];
        end
    end

    assign rd_data     = r_rd_data;
    assign busy        = r_busy;
    assign triggered   = r_triggered;
    assign done        = r_done;
    assign capture_len = r_capture_len;
endmodule
